// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, ALU ops, mux codes and state encodings.
// Optional feature macro: MIPS_CTRL_JUMP_EN (adds the J instruction).
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_SIGNEX = 2'b10;
    localparam logic [1:0] SRCB_SHIFT2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_MADR   = 4'd3;
    localparam logic [3:0] ST_MRD    = 4'd4;
    localparam logic [3:0] ST_MWB    = 4'd5;
    localparam logic [3:0] ST_MWR    = 4'd6;
    localparam logic [3:0] ST_REX    = 4'd7;
    localparam logic [3:0] ST_RWB    = 4'd8;
    localparam logic [3:0] ST_BEQ    = 4'd9;
    localparam logic [3:0] ST_AEX    = 4'd10;
    localparam logic [3:0] ST_AWB    = 4'd11;
    localparam logic [3:0] ST_JMP    = 4'd12;

    // True for every opcode the controller can sequence in this build.
    function automatic logic is_supported(input logic [5:0] op);
        logic ok;
        ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI);
`ifdef MIPS_CTRL_JUMP_EN
        ok = ok || (op == OP_J);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing the shared-ALU/shared-memory MIPS datapath; counts retired instructions.
// Optional feature macro: MIPS_CTRL_JUMP_EN (DECODE maps opcode 0x02 to a JMP state).
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_en,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic [3:0]          state,
    output logic [RETIRE_W-1:0] retire_count,
    output logic                illegal_op
);

    logic [3:0] next_state;
    logic [5:0] op_q;
    logic       pc_write;
    logic       pc_write_cond;
    logic       retire_event;

    // reset is active-low; state, op_q and the retire counter clear asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            op_q         <= 6'd0;
            retire_count <= '0;
        end else begin
            state <= next_state;
            if (state == ST_DECODE) begin
                op_q <= opcode;
            end
            if (retire_event) begin
                retire_count <= retire_count + RETIRE_W'(1);
            end
        end
    end

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:   next_state = ST_FETCH;
            ST_FETCH:  next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = ST_REX;
                    OP_LW, OP_SW: next_state = ST_MADR;
                    OP_BEQ:       next_state = ST_BEQ;
                    OP_ADDI:      next_state = ST_AEX;
`ifdef MIPS_CTRL_JUMP_EN
                    OP_J:         next_state = ST_JMP;
`endif
                    default:      next_state = ST_FETCH;
                endcase
            end
            ST_MADR:   next_state = (op_q == OP_SW) ? ST_MWR : ST_MRD;
            ST_MRD:    next_state = mem_ready ? ST_MWB : ST_MRD;
            ST_MWR:    next_state = mem_ready ? ST_FETCH : ST_MWR;
            ST_REX:    next_state = ST_RWB;
            ST_AEX:    next_state = ST_AWB;
            ST_MWB, ST_RWB, ST_BEQ, ST_AWB: next_state = ST_FETCH;
`ifdef MIPS_CTRL_JUMP_EN
            ST_JMP:    next_state = ST_FETCH;
`endif
            default:   next_state = ST_IDLE;
        endcase
    end

    // Store completes only on mem_ready; every other retiring state lasts exactly one cycle.
    always_comb begin
        retire_event = 1'b0;
        case (state)
            ST_MWB, ST_RWB, ST_BEQ, ST_AWB: retire_event = 1'b1;
            ST_MWR:  retire_event = mem_ready;
`ifdef MIPS_CTRL_JUMP_EN
            ST_JMP:  retire_event = 1'b1;
`endif
            default: retire_event = 1'b0;
        endcase
    end

    always_comb begin
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        illegal_op    = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b  = SRCB_SHIFT2;
                illegal_op = !is_supported(opcode);
            end
            ST_MADR, ST_AEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SIGNEX;
            end
            ST_MRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_REX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_source     = PCSRC_ALUOUT;
                pc_write_cond = 1'b1;
            end
            ST_AWB: reg_write = 1'b1;
`ifdef MIPS_CTRL_JUMP_EN
            ST_JMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
`endif
            default: ;
        endcase
    end

    assign pc_en = pc_write | (pc_write_cond & zero);

endmodule
